// File: rtl/npu_pkg.sv
// Shared NPU definitions: perf-counter chain flit, counter request types,
// output-register state and the default header width.
package npu_pkg;

  localparam int HDR_W_DEF = 128;

  localparam logic [3:0] PC_TYPE_ACC   = 4'd0;
  localparam logic [3:0] PC_TYPE_STALL = 4'd1;
  localparam logic [3:0] PC_TYPE_RDCLR = 4'd2;

  localparam logic [15:0] PC_VALUE_BAD = 16'hFFFF;

  typedef struct packed {
    logic        request;
    logic [15:0] moduleId;
    logic [7:0]  portId;
    logic [15:0] pcValue;
    logic [3:0]  pcType;
  } pc_flit_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/npu_ingress_arbiter_if.sv
// Bundle of the ingress ports, the registered output toward Top and the
// perf-counter chain in/out. master = surrounding system, slave = arbiter.
interface npu_ingress_arbiter_if #(
  parameter int NPORTS = 4,
  parameter int HDR_W  = 128
);
  localparam int PW = $clog2(NPORTS);

  logic [NPORTS-1:0]       in_valid;
  logic [NPORTS-1:0]       in_ready;
  logic [NPORTS*HDR_W-1:0] in_bits;

  logic                    out_valid;
  logic                    out_ready;
  logic [HDR_W-1:0]        out_bits;
  logic [PW-1:0]           out_port;

  logic                    pcIn_valid;
  logic                    pcIn_bits_request;
  logic [15:0]             pcIn_bits_moduleId;
  logic [7:0]              pcIn_bits_portId;
  logic [15:0]             pcIn_bits_pcValue;
  logic [3:0]              pcIn_bits_pcType;

  logic                    pcOut_valid;
  logic                    pcOut_bits_request;
  logic [15:0]             pcOut_bits_moduleId;
  logic [7:0]              pcOut_bits_portId;
  logic [15:0]             pcOut_bits_pcValue;
  logic [3:0]              pcOut_bits_pcType;

  modport master (
    output in_valid, in_bits, out_ready,
    output pcIn_valid, pcIn_bits_request, pcIn_bits_moduleId,
    output pcIn_bits_portId, pcIn_bits_pcValue, pcIn_bits_pcType,
    input  in_ready, out_valid, out_bits, out_port,
    input  pcOut_valid, pcOut_bits_request, pcOut_bits_moduleId,
    input  pcOut_bits_portId, pcOut_bits_pcValue, pcOut_bits_pcType
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    input  pcIn_valid, pcIn_bits_request, pcIn_bits_moduleId,
    input  pcIn_bits_portId, pcIn_bits_pcValue, pcIn_bits_pcType,
    output in_ready, out_valid, out_bits, out_port,
    output pcOut_valid, pcOut_bits_request, pcOut_bits_moduleId,
    output pcOut_bits_portId, pcOut_bits_pcValue, pcOut_bits_pcType
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. Returns one-hot grant, its index and an any flag.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan offsets from farthest to nearest so the nearest valid port wins.
  always_comb begin
    int p;
    gnt = '0;
    idx = '0;
    any = |req;
    p   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (req[p]) begin
        gnt    = '0;
        gnt[p] = 1'b1;
        idx    = W'(p);
      end
    end
  end

endmodule

// File: rtl/npu_ingress_arbiter.sv
// Round-robin ingress arbiter in front of the NPU header pipeline, with a
// one-entry output register, per-port accept/stall counters and a perf node
// sitting in series on the pc chain.
module npu_ingress_arbiter
  import npu_pkg::*;
#(
  parameter int          NPORTS    = 4,
  parameter int          HDR_W     = HDR_W_DEF,
  parameter logic [15:0] MODULE_ID = 16'h0010,
  parameter int          CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  npu_ingress_arbiter_if.slave  bus
);

  localparam int PW = $clog2(NPORTS);

  // ---------------- arbitration and output register ----------------
  logic [HDR_W-1:0]  hdr_arr [NPORTS];
  logic [NPORTS-1:0] pick_gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              load;
  logic [NPORTS-1:0] in_ready;

  out_state_e        state_q, state_d;
  logic [HDR_W-1:0]  out_bits_q, out_bits_d;
  logic [PW-1:0]     out_port_q, out_port_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_hdr
    assign hdr_arr[gi] = bus.in_bits[gi*HDR_W +: HDR_W];
  end

  rr_pick #(.N(NPORTS), .W(PW)) u_pick (
    .req (bus.in_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The register can take a new header when empty or draining this cycle.
  assign load     = (state_q == OUT_EMPTY) || bus.out_ready;
  assign in_ready = (load && !reset) ? pick_gnt : '0;

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    state_d    = state_q;
    out_bits_d = out_bits_q;
    out_port_d = out_port_q;
    rr_ptr_d   = rr_ptr_q;
    if (load) begin
      if (pick_any) begin
        state_d    = OUT_FULL;
        out_bits_d = hdr_arr[pick_idx];
        out_port_d = pick_idx;
        rr_ptr_d   = (pick_idx == PW'(NPORTS - 1)) ? '0 : pick_idx + 1'b1;
      end else begin
        state_d = OUT_EMPTY;
      end
    end
  end

  // Output register and pointer flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OUT_EMPTY;
      out_bits_q <= '0;
      out_port_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_bits_q <= out_bits_d;
      out_port_q <= out_port_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUT_FULL);
  assign bus.out_bits  = out_bits_q;
  assign bus.out_port  = out_port_q;

  // ---------------- perf node and counters ----------------
  logic [CNT_W-1:0]  acc_q [NPORTS];
  logic [CNT_W-1:0]  acc_d [NPORTS];
  logic [CNT_W-1:0]  stl_q [NPORTS];
  logic [CNT_W-1:0]  stl_d [NPORTS];
  logic [NPORTS-1:0] clr_port;

  pc_flit_t          pc_in, pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              pc_match;
  logic [PW-1:0]     pc_sel;

  assign pc_in = '{request:  bus.pcIn_bits_request,
                   moduleId: bus.pcIn_bits_moduleId,
                   portId:   bus.pcIn_bits_portId,
                   pcValue:  bus.pcIn_bits_pcValue,
                   pcType:   bus.pcIn_bits_pcType};

  assign pc_sel   = bus.pcIn_bits_portId[PW-1:0];
  assign pc_match = bus.pcIn_valid && bus.pcIn_bits_request &&
                    (bus.pcIn_bits_moduleId == MODULE_ID) &&
                    (bus.pcIn_bits_portId < 8'(NPORTS));

  // Answer matching requests from pre-increment counters; forward the rest.
  always_comb begin
    pc_valid_d = bus.pcIn_valid;
    pc_d       = pc_in;
    clr_port   = '0;
    if (pc_match) begin
      pc_d.request = 1'b0;
      case (bus.pcIn_bits_pcType)
        PC_TYPE_ACC:   pc_d.pcValue = 16'(acc_q[pc_sel]);
        PC_TYPE_STALL: pc_d.pcValue = 16'(stl_q[pc_sel]);
        PC_TYPE_RDCLR: begin
          pc_d.pcValue     = 16'(acc_q[pc_sel]);
          clr_port[pc_sel] = 1'b1;
        end
        default:       pc_d.pcValue = PC_VALUE_BAD;
      endcase
    end
  end

  // Counter update: clear first, then add this cycle's event.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      acc_d[p] = (clr_port[p] ? '0 : acc_q[p]) +
                 CNT_W'(bus.in_valid[p] && in_ready[p]);
      stl_d[p] = (clr_port[p] ? '0 : stl_q[p]) +
                 CNT_W'(bus.in_valid[p] && !in_ready[p]);
    end
  end

  // Counter and pc-chain flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        acc_q[p] <= '0;
        stl_q[p] <= '0;
      end
      pc_valid_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        acc_q[p] <= acc_d[p];
        stl_q[p] <= stl_d[p];
      end
      pc_valid_q <= pc_valid_d;
      pc_q       <= pc_d;
    end
  end

  assign bus.pcOut_valid         = pc_valid_q;
  assign bus.pcOut_bits_request  = pc_q.request;
  assign bus.pcOut_bits_moduleId = pc_q.moduleId;
  assign bus.pcOut_bits_portId   = pc_q.portId;
  assign bus.pcOut_bits_pcValue  = pc_q.pcValue;
  assign bus.pcOut_bits_pcType   = pc_q.pcType;

endmodule

// File: tb/tb_npu_ingress_arbiter.sv
// Bench for npu_ingress_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbiter, counters and perf node.
module tb_npu_ingress_arbiter;

  localparam int N = 4;
  localparam int H = 128;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  npu_ingress_arbiter_if #(.NPORTS(N), .HDR_W(H)) bus ();

  npu_ingress_arbiter #(
    .NPORTS(N), .HDR_W(H), .MODULE_ID(16'h0010), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_full, m_port, m_rr;
  logic [H-1:0] m_bits;
  int          m_acc [N];
  int          m_stl [N];
  logic        m_pcv, m_pc_req;
  logic [15:0] m_pc_mid, m_pc_val;
  logic [7:0]  m_pc_pid;
  logic [3:0]  m_pc_typ;

  function automatic logic [3:0] model_ready();
    int p;
    if (reset) return 4'b0;
    if (m_full != 0 && !bus.out_ready) return 4'b0;
    for (int k = 0; k < N; k++) begin
      p = (m_rr + k) % N;
      if (bus.in_valid[p]) return 4'(1 << p);
    end
    return 4'b0;
  endfunction

  function automatic logic [H-1:0] rand_hdr();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic randomize_bits();
    for (int p = 0; p < N; p++) bus.in_bits[p*H +: H] = rand_hdr();
  endtask

  task automatic pc_drive(input logic [15:0] mid, input logic [7:0] pid,
                          input logic [3:0] typ, input logic req);
    bus.pcIn_valid         = 1'b1;
    bus.pcIn_bits_request  = req;
    bus.pcIn_bits_moduleId = mid;
    bus.pcIn_bits_portId   = pid;
    bus.pcIn_bits_pcValue  = 16'($urandom);
    bus.pcIn_bits_pcType   = typ;
  endtask

  // One clock edge; the model follows the rules applied to the inputs seen.
  task automatic tick();
    logic [3:0]       r, v;
    logic             rdy, rst, pv, preq;
    logic [N*H-1:0]   bits;
    logic [15:0]      pmid, pval;
    logic [7:0]       ppid;
    logic [3:0]       ptyp;
    int               clr, g;
    r = model_ready(); v = bus.in_valid; rdy = bus.out_ready; rst = reset;
    bits = bus.in_bits;
    pv = bus.pcIn_valid; preq = bus.pcIn_bits_request;
    pmid = bus.pcIn_bits_moduleId; ppid = bus.pcIn_bits_portId;
    pval = bus.pcIn_bits_pcValue; ptyp = bus.pcIn_bits_pcType;
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_port = 0; m_rr = 0; m_bits = '0;
      for (int p = 0; p < N; p++) begin m_acc[p] = 0; m_stl[p] = 0; end
      m_pcv = 0; m_pc_req = 0; m_pc_mid = 0; m_pc_pid = 0; m_pc_val = 0; m_pc_typ = 0;
    end else begin
      clr = -1;
      m_pcv = pv; m_pc_req = preq; m_pc_mid = pmid; m_pc_pid = ppid;
      m_pc_val = pval; m_pc_typ = ptyp;
      if (pv && preq && pmid == 16'h0010 && ppid < 8'(N)) begin
        m_pc_req = 1'b0;
        case (ptyp)
          4'd0: m_pc_val = 16'(m_acc[ppid]);
          4'd1: m_pc_val = 16'(m_stl[ppid]);
          4'd2: begin m_pc_val = 16'(m_acc[ppid]); clr = int'(ppid); end
          default: m_pc_val = 16'hFFFF;
        endcase
      end
      for (int p = 0; p < N; p++) begin
        if (p == clr) begin m_acc[p] = 0; m_stl[p] = 0; end
        if (v[p] && r[p])  m_acc[p] = (m_acc[p] + 1) % 65536;
        if (v[p] && !r[p]) m_stl[p] = (m_stl[p] + 1) % 65536;
      end
      if (m_full == 0 || rdy) begin
        if (r != 0) begin
          g = 0;
          for (int p = 0; p < N; p++) if (r[p]) g = p;
          m_full = 1; m_bits = bits[g*H +: H]; m_port = g; m_rr = (g + 1) % N;
        end else begin
          m_full = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.in_valid = '0; bus.pcIn_valid = 1'b0; bus.out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; bus.in_valid = 4'hF; bus.out_ready = 1'b1; bus.pcIn_valid = 1'b0;
    randomize_bits();
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 4'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready);
    end
    tick(); tick();
    reset = 1'b0; bus.in_valid = '0;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_bits !== '0 || bus.out_port !== 2'd0) begin
      n_fail++; $display("FAIL reset_out: valid=%b port=%0d bits=%h want 0", bus.out_valid, bus.out_port, bus.out_bits);
    end
    n_tests++;
    if (bus.pcOut_valid !== 1'b0 || bus.pcOut_bits_pcValue !== 16'd0 || bus.pcOut_bits_moduleId !== 16'd0) begin
      n_fail++; $display("FAIL reset_pc: valid=%b val=%h mid=%h want 0", bus.pcOut_valid, bus.pcOut_bits_pcValue, bus.pcOut_bits_moduleId);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_round_robin();
    logic [H-1:0] cap;
    do_reset();
    bus.in_valid = 4'hF; bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      randomize_bits();
      cap = bus.in_bits[(i%N)*H +: H];
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== 4'(1 << (i % N))) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.in_ready, 4'(1 << (i % N)));
      end
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_port !== 2'(i % N) || bus.out_bits !== cap) begin
        n_fail++; $display("FAIL rr_out[%0d]: valid=%b port=%0d want 1/%0d", i, bus.out_valid, bus.out_port, i % N);
      end
      $display("[TB] rr cycle %0d port %0d", i, bus.out_port);
    end
    bus.in_valid = '0;
  endtask

  task automatic test_single_port();
    do_reset();
    bus.in_valid = 4'b0100; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      randomize_bits();
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== 4'b0100) begin
        n_fail++; $display("FAIL single_grant[%0d]: got %b want 0100", i, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = '0;
    pc_drive(16'h0010, 8'd2, 4'd0, 1'b1);
    tick();
    bus.pcIn_valid = 1'b0;
    n_tests++;
    if (bus.pcOut_valid !== 1'b1 || bus.pcOut_bits_request !== 1'b0 || bus.pcOut_bits_pcValue !== 16'd5 ||
        bus.pcOut_bits_portId !== 8'd2) begin
      n_fail++; $display("FAIL acc2_read: v=%b req=%b val=%0d pid=%0d want 1/0/5/2", bus.pcOut_valid,
                         bus.pcOut_bits_request, bus.pcOut_bits_pcValue, bus.pcOut_bits_portId);
    end
    $display("[TB] test_single_port acc[2]=%0d", bus.pcOut_bits_pcValue);
  endtask

  task automatic test_stall();
    logic [H-1:0] cap;
    do_reset();
    bus.in_valid = 4'b0010; bus.out_ready = 1'b0;
    randomize_bits();
    cap = bus.in_bits[1*H +: H];
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 4'b0010) begin
      n_fail++; $display("FAIL stall_first: got %b want 0010", bus.in_ready);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      randomize_bits();
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== 4'b0) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b want 0000", i, bus.in_ready);
      end
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_bits !== cap) begin
        n_fail++; $display("FAIL stall_hold[%0d]: valid=%b bits=%h want %h", i, bus.out_valid, bus.out_bits, cap);
      end
    end
    bus.in_valid = '0;
    pc_drive(16'h0010, 8'd1, 4'd1, 1'b1);
    tick();
    bus.pcIn_valid = 1'b0;
    n_tests++;
    if (bus.pcOut_bits_pcValue !== 16'd4) begin
      n_fail++; $display("FAIL stl1_read: got %0d want 4", bus.pcOut_bits_pcValue);
    end
    $display("[TB] test_stall stl[1]=%0d", bus.pcOut_bits_pcValue);
  endtask

  task automatic test_rdclr();
    do_reset();
    bus.in_valid = 4'b0001; bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin randomize_bits(); tick(); end
    pc_drive(16'h0010, 8'd0, 4'd2, 1'b1);
    tick();
    n_tests++;
    if (bus.pcOut_bits_pcValue !== 16'd7 || bus.pcOut_bits_pcType !== 4'd2) begin
      n_fail++; $display("FAIL rdclr_value: got %0d type %0d want 7 type 2", bus.pcOut_bits_pcValue, bus.pcOut_bits_pcType);
    end
    bus.in_valid = '0;
    pc_drive(16'h0010, 8'd0, 4'd0, 1'b1);
    tick();
    bus.pcIn_valid = 1'b0;
    n_tests++;
    if (bus.pcOut_bits_pcValue !== 16'd1) begin
      n_fail++; $display("FAIL rdclr_after: got %0d want 1", bus.pcOut_bits_pcValue);
    end
    $display("[TB] test_rdclr after-clear=%0d", bus.pcOut_bits_pcValue);
  endtask

  task automatic test_passthrough();
    logic [44:0] sent;
    do_reset();
    pc_drive(16'h0020, 8'd1, 4'd0, 1'b1);
    sent = {1'b1, 16'h0020, 8'd1, bus.pcIn_bits_pcValue, 4'd0};
    tick();
    n_tests++;
    if ({bus.pcOut_bits_request, bus.pcOut_bits_moduleId, bus.pcOut_bits_portId,
         bus.pcOut_bits_pcValue, bus.pcOut_bits_pcType} !== sent || bus.pcOut_valid !== 1'b1) begin
      n_fail++; $display("FAIL pass_mid: got mid=%h val=%h want %h", bus.pcOut_bits_moduleId, bus.pcOut_bits_pcValue, sent);
    end
    pc_drive(16'h0010, 8'd9, 4'd1, 1'b1);
    sent = {1'b1, 16'h0010, 8'd9, bus.pcIn_bits_pcValue, 4'd1};
    tick();
    n_tests++;
    if ({bus.pcOut_bits_request, bus.pcOut_bits_moduleId, bus.pcOut_bits_portId,
         bus.pcOut_bits_pcValue, bus.pcOut_bits_pcType} !== sent) begin
      n_fail++; $display("FAIL pass_pid: got pid=%0d val=%h req=%b", bus.pcOut_bits_portId, bus.pcOut_bits_pcValue, bus.pcOut_bits_request);
    end
    pc_drive(16'h0010, 8'd3, 4'd7, 1'b1);
    tick();
    bus.pcIn_valid = 1'b0;
    n_tests++;
    if (bus.pcOut_bits_pcValue !== 16'hFFFF || bus.pcOut_bits_request !== 1'b0) begin
      n_fail++; $display("FAIL bad_type: got %h req=%b want FFFF/0", bus.pcOut_bits_pcValue, bus.pcOut_bits_request);
    end
    $display("[TB] test_passthrough done");
  endtask

  task automatic test_random();
    logic [3:0] t;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      randomize_bits();
      if ($urandom_range(0, 2) == 0) begin
        t = 4'($urandom_range(0, 4));
        if (t == 4'd4) t = 4'hF;
        pc_drive(($urandom_range(0, 3) != 0) ? 16'h0010 : 16'($urandom),
                 8'($urandom_range(0, 5)), t, $urandom_range(0, 4) != 0);
      end else begin
        bus.pcIn_valid = 1'b0;
      end
      @(negedge clk);
      n_tests++;
      if (bus.in_ready !== model_ready()) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, bus.in_ready, model_ready());
      end
      tick();
      n_tests++;
      if (bus.out_valid !== (m_full != 0) ||
          (m_full != 0 && (bus.out_bits !== m_bits || bus.out_port !== 2'(m_port)))) begin
        n_fail++; $display("FAIL rnd_out[%0d]: v=%b port=%0d want v=%0d port=%0d", i, bus.out_valid, bus.out_port, m_full, m_port);
      end
      n_tests++;
      if (bus.pcOut_valid !== m_pcv ||
          {bus.pcOut_bits_request, bus.pcOut_bits_moduleId, bus.pcOut_bits_portId,
           bus.pcOut_bits_pcValue, bus.pcOut_bits_pcType} !==
          {m_pc_req, m_pc_mid, m_pc_pid, m_pc_val, m_pc_typ}) begin
        n_fail++; $display("FAIL rnd_pc[%0d]: v=%b val=%h want v=%b val=%h", i, bus.pcOut_valid,
                           bus.pcOut_bits_pcValue, m_pcv, m_pc_val);
      end
    end
    bus.pcIn_valid = 1'b0; bus.in_valid = '0;
    $display("[TB] test_random done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.in_valid = 4'b1000; bus.out_ready = 1'b0;
    randomize_bits();
    tick(); tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 4'b0) begin
      n_fail++; $display("FAIL midrst_ready: got %b want 0000", bus.in_ready);
    end
    tick();
    reset = 1'b0; bus.in_valid = '0;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid);
    end
    for (int p = 0; p < N; p++) begin
      for (int t = 0; t < 2; t++) begin
        pc_drive(16'h0010, 8'(p), 4'(t), 1'b1);
        tick();
        n_tests++;
        if (bus.pcOut_bits_pcValue !== 16'd0) begin
          n_fail++; $display("FAIL midrst_cnt p%0d t%0d: got %0d want 0", p, t, bus.pcOut_bits_pcValue);
        end
      end
    end
    bus.pcIn_valid = 1'b0;
    bus.in_valid = 4'hF; bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_ptr: got %b want 0001", bus.in_ready);
    end
    tick();
    bus.in_valid = '0;
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    bus.in_valid = '0; bus.in_bits = '0; bus.out_ready = 1'b0;
    bus.pcIn_valid = 1'b0; bus.pcIn_bits_request = 1'b0; bus.pcIn_bits_moduleId = '0;
    bus.pcIn_bits_portId = '0; bus.pcIn_bits_pcValue = '0; bus.pcIn_bits_pcType = '0;
    m_full = 0; m_port = 0; m_rr = 0; m_bits = '0;
    for (int p = 0; p < N; p++) begin m_acc[p] = 0; m_stl[p] = 0; end
    m_pcv = 0; m_pc_req = 0; m_pc_mid = 0; m_pc_pid = 0; m_pc_val = 0; m_pc_typ = 0;
    test_reset();
    test_round_robin();
    test_single_port();
    test_stall();
    test_rdclr();
    test_passthrough();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
